// File: rtl/lc3_pipe_ctrl.sv
// lc3_pipe_ctrl: LC3 pipeline stage sequencing, data-memory access FSM, branch redirect and ALU hazard handling.
// Build option LC3_CTRL_BYPASS_EN: forward ALU results to operands instead of stalling on a RAW hazard.
module lc3_pipe_ctrl #(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] IR,
    input  logic [15:0] IR_Exec,
    input  logic [2:0]  psr,
    input  logic        complete_instr,
    input  logic        complete_data,
    output logic        enable_fetch,
    output logic        enable_decode,
    output logic        enable_execute,
    output logic        enable_writeback,
    output logic        enable_updatePC,
    output logic        br_taken,
    output logic [1:0]  mem_state,
    output logic        bypass_alu_1,
    output logic        bypass_alu_2,
    output logic        mem_timeout
);
    typedef enum logic [1:0] {
        MS_READ  = 2'd0,
        MS_IND   = 2'd1,
        MS_WRITE = 2'd2,
        MS_IDLE  = 2'd3
    } mem_state_t;

    localparam logic [3:0] OP_BR  = 4'b0000, OP_ADD = 4'b0001, OP_LD  = 4'b0010,
                           OP_ST  = 4'b0011, OP_AND = 4'b0101, OP_LDR = 4'b0110,
                           OP_STR = 4'b0111, OP_NOT = 4'b1001, OP_LDI = 4'b1010,
                           OP_STI = 4'b1011, OP_JMP = 4'b1100;
    localparam logic [2:0] FILL_DONE = 3'd4;

    logic [3:0] op_id, op_ex;
    logic       alu_id, alu_ex, ctrl_id, hz1, hz2;
    logic       unused_ir_bits;

    assign op_id   = IR[15:12];
    assign op_ex   = IR_Exec[15:12];
    assign alu_id  = (op_id == OP_ADD) || (op_id == OP_AND) || (op_id == OP_NOT);
    assign alu_ex  = (op_ex == OP_ADD) || (op_ex == OP_AND) || (op_ex == OP_NOT);
    assign ctrl_id = (op_id == OP_BR) || (op_id == OP_JMP);
    assign unused_ir_bits = ^{IR[11:9], IR[4:3], IR_Exec[8:0]};

    // SR1 always a register source; SR2 only in register mode (NOT has no SR2)
    assign hz1 = alu_id && alu_ex && (IR[8:6] == IR_Exec[11:9]);
    assign hz2 = alu_id && alu_ex && (op_id != OP_NOT) && !IR[5] && (IR[2:0] == IR_Exec[11:9]);

`ifdef LC3_CTRL_BYPASS_EN
    assign bypass_alu_1 = hz1;
    assign bypass_alu_2 = hz2;
`else
    logic hazard, stall_q, stall_d;
    assign hazard       = hz1 || hz2;
    assign bypass_alu_1 = 1'b0;
    assign bypass_alu_2 = 1'b0;
`endif

    mem_state_t state_q, state_d;
    logic [3:0] wait_q, wait_d;
    logic       ind_load_q, ind_load_d, timeout_d;
    logic [2:0] fill_q, fill_d, drain_q, drain_d;
    logic       fe_d, de_d, ex_d, wb_d, up_d, br_d;

    assign mem_state = state_q;

    // Memory FSM; the indirect op's direction is latched so IR_Exec may move on
    always_comb begin
        state_d    = state_q;
        wait_d     = wait_q;
        ind_load_d = ind_load_q;
        timeout_d  = mem_timeout;
        case (state_q)
            MS_IDLE: if (complete_data) begin
                if (op_ex == OP_LD || op_ex == OP_LDR) begin
                    state_d = MS_READ;
                end else if (op_ex == OP_LDI || op_ex == OP_STI) begin
                    state_d    = MS_IND;
                    ind_load_d = (op_ex == OP_LDI);
                end else if (op_ex == OP_ST || op_ex == OP_STR) begin
                    state_d = MS_WRITE;
                end
            end
            MS_IND:  if (complete_data) state_d = ind_load_q ? MS_READ : MS_WRITE;
            default: if (complete_data) state_d = MS_IDLE;
        endcase
        if (state_q != MS_IDLE) begin
            if (complete_data) begin
                wait_d = 4'd0;
            end else if (wait_q == 4'(MEM_TIMEOUT - 1)) begin
                state_d   = MS_IDLE;
                wait_d    = 4'd0;
                timeout_d = 1'b1;
            end else begin
                wait_d = wait_q + 4'd1;
            end
        end
    end

    // Stage enables: memory access > fill > control drain > decode CTRL > hazard stall > run
    always_comb begin
        fe_d    = 1'b0;
        de_d    = 1'b0;
        ex_d    = 1'b0;
        wb_d    = 1'b0;
        up_d    = 1'b0;
        br_d    = 1'b0;
        fill_d  = (fill_q != FILL_DONE && complete_instr) ? fill_q + 3'd1 : fill_q;
        drain_d = 3'd0;
`ifndef LC3_CTRL_BYPASS_EN
        stall_d = 1'b0;
`endif
        if (state_d != MS_IDLE) begin
            wb_d    = (state_d == MS_READ);
            drain_d = drain_q;
        end else if (fill_q != FILL_DONE) begin
            fe_d = (fill_d >= 3'd1);
            up_d = (fill_d >= 3'd1);
            de_d = (fill_d >= 3'd2);
            ex_d = (fill_d >= 3'd3);
            wb_d = (fill_d >= 3'd4);
        end else if (drain_q != 3'd0) begin
            wb_d    = 1'b1;
            drain_d = (drain_q == 3'd4) ? 3'd0 : drain_q + 3'd1;
            case (drain_d)
                3'd2: begin
                    up_d = 1'b1;
                    br_d = (op_ex == OP_JMP) || (op_ex == OP_BR && |(IR_Exec[11:9] & psr));
                end
                3'd3: begin
                    fe_d = 1'b1;
                    up_d = 1'b1;
                end
                3'd4: begin
                    fe_d = 1'b1;
                    de_d = 1'b1;
                    up_d = 1'b1;
                end
                default: begin
                    fe_d = 1'b1;
                    de_d = 1'b1;
                    ex_d = 1'b1;
                    up_d = 1'b1;
                end
            endcase
        end else if (ctrl_id) begin
            drain_d = 3'd1;
            ex_d    = 1'b1;
            wb_d    = 1'b1;
`ifndef LC3_CTRL_BYPASS_EN
        end else if (hazard && !stall_q) begin
            stall_d = 1'b1;
            wb_d    = 1'b1;
`endif
        end else begin
            fe_d = 1'b1;
            de_d = 1'b1;
            ex_d = 1'b1;
            wb_d = 1'b1;
            up_d = 1'b1;
        end
        if (!complete_instr) begin
            fe_d = 1'b0;
            de_d = 1'b0;
            ex_d = 1'b0;
            up_d = 1'b0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q          <= MS_IDLE;
            wait_q           <= 4'd0;
            ind_load_q       <= 1'b0;
            mem_timeout      <= 1'b0;
            fill_q           <= 3'd0;
            drain_q          <= 3'd0;
            enable_fetch     <= 1'b0;
            enable_decode    <= 1'b0;
            enable_execute   <= 1'b0;
            enable_writeback <= 1'b0;
            enable_updatePC  <= 1'b0;
            br_taken         <= 1'b0;
`ifndef LC3_CTRL_BYPASS_EN
            stall_q          <= 1'b0;
`endif
        end else begin
            state_q          <= state_d;
            wait_q           <= wait_d;
            ind_load_q       <= ind_load_d;
            mem_timeout      <= timeout_d;
            fill_q           <= fill_d;
            drain_q          <= drain_d;
            enable_fetch     <= fe_d;
            enable_decode    <= de_d;
            enable_execute   <= ex_d;
            enable_writeback <= wb_d;
            enable_updatePC  <= up_d;
            br_taken         <= br_d;
`ifndef LC3_CTRL_BYPASS_EN
            stall_q          <= stall_d;
`endif
        end
    end
endmodule

// File: tb/tb_lc3_pipe_ctrl.sv
// Self-checking bench for lc3_pipe_ctrl: fill, memory FSM paths, branch drain, hazards, timeout, async reset.
module tb_lc3_pipe_ctrl;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] IR = 16'hD000, IR_Exec = 16'hD000;
    logic [2:0]  psr = 3'd0;
    logic        complete_instr = 1'b1, complete_data = 1'b0;
    logic        enable_fetch, enable_decode, enable_execute, enable_writeback, enable_updatePC;
    logic        br_taken, bypass_alu_1, bypass_alu_2, mem_timeout;
    logic [1:0]  mem_state;
    logic [4:0]  en;

`ifdef LC3_CTRL_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif
    localparam logic [15:0] NEUT = 16'hD000;

    int vectors = 0, miscompares = 0;

    lc3_pipe_ctrl #(.MEM_TIMEOUT(15)) dut (
        .clock(clock), .reset(reset), .IR(IR), .IR_Exec(IR_Exec), .psr(psr),
        .complete_instr(complete_instr), .complete_data(complete_data),
        .enable_fetch(enable_fetch), .enable_decode(enable_decode),
        .enable_execute(enable_execute), .enable_writeback(enable_writeback),
        .enable_updatePC(enable_updatePC), .br_taken(br_taken), .mem_state(mem_state),
        .bypass_alu_1(bypass_alu_1), .bypass_alu_2(bypass_alu_2), .mem_timeout(mem_timeout)
    );

    always #5 clock = ~clock;

    // enable vector order: fetch, decode, execute, writeback, updatePC
    assign en = {enable_fetch, enable_decode, enable_execute, enable_writeback, enable_updatePC};

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic bit is_alu(input logic [15:0] i);
        return (i[15:12] == 4'h1) || (i[15:12] == 4'h5) || (i[15:12] == 4'h9);
    endfunction

    function automatic logic [15:0] mk(input logic [3:0] op);
        logic [2:0] dr, s1, s2;
        logic       imm;
        dr  = 3'($urandom_range(0, 3));
        s1  = 3'($urandom_range(0, 3));
        s2  = 3'($urandom_range(0, 3));
        imm = 1'($urandom_range(0, 1));
        return {op, dr, s1, imm, 2'b00, s2};
    endfunction

    task automatic fill_check(input string tag);
        for (int k = 1; k <= 5; k++) begin
            tick();
            chk({tag, "_en"}, 16'(en), 16'({k >= 1, k >= 2, k >= 3, k >= 4, k >= 1}));
            chk({tag, "_ms"}, 16'(mem_state), 16'd3);
        end
    endtask

    initial begin
        logic [3:0]  plain_ops [8];
        logic [3:0]  mem_ops [6];
        logic [1:0]  path [$];
        logic [15:0] ir, ix, ctrl;
        logic [2:0]  nzp, p;
        bit          a1, a2, stall, stalled, ci, jmp, exp_br;
        int          w;

        plain_ops = '{4'h1, 4'h5, 4'h9, 4'hE, 4'hD, 4'hF, 4'h4, 4'h8};
        mem_ops   = '{4'h2, 4'h6, 4'h3, 4'h7, 4'hA, 4'hB};

        // reset values
        repeat (2) @(posedge clock);
        #1;
        chk("rst_en", 16'(en), 16'd0);
        chk("rst_ms", 16'(mem_state), 16'd3);
        chk("rst_br", 16'(br_taken), 16'd0);
        chk("rst_to", 16'(mem_timeout), 16'd0);
        chk("rst_byp", 16'({bypass_alu_1, bypass_alu_2}), 16'd0);
        reset = 1'b0;
        fill_check("fill");

        // memory accesses: first three directed, rest randomized
        for (int n = 0; n < 16; n++) begin
            if (n == 0)      ix = 16'h2202;
            else if (n == 1) ix = 16'hA202;
            else if (n == 2) ix = 16'hB202;
            else             ix = {mem_ops[$urandom_range(0, 5)], 12'($urandom)};
            path = {};
            case (ix[15:12])
                4'h2, 4'h6: path.push_back(2'd0);
                4'h3, 4'h7: path.push_back(2'd2);
                4'hA: begin path.push_back(2'd1); path.push_back(2'd0); end
                default: begin path.push_back(2'd1); path.push_back(2'd2); end
            endcase
            IR = NEUT; IR_Exec = ix; complete_data = 1'b0;
            w = (n == 0) ? 2 : (n < 3) ? 0 : $urandom_range(0, 3);
            repeat (w) begin
                tick();
                chk("mem_wait_ms", 16'(mem_state), 16'd3);
                chk("mem_wait_en", 16'(en), 16'b11111);
            end
            complete_data = 1'b1;
            tick();
            IR_Exec = NEUT;
            foreach (path[i]) begin
                chk("mem_ms", 16'(mem_state), 16'(path[i]));
                chk("mem_en", 16'(en), (path[i] == 2'd0) ? 16'b00010 : 16'b00000);
                w = (n < 3) ? 0 : $urandom_range(0, 4);
                complete_data = 1'b0;
                repeat (w) begin
                    tick();
                    chk("mem_hold_ms", 16'(mem_state), 16'(path[i]));
                    chk("mem_hold_en", 16'(en), (path[i] == 2'd0) ? 16'b00010 : 16'b00000);
                end
                complete_data = 1'b1;
                tick();
            end
            chk("mem_end_ms", 16'(mem_state), 16'd3);
            chk("mem_end_en", 16'(en), 16'b11111);
        end
        complete_data = 1'b0;

        // control drain: BRz directed, then random BR/JMP
        for (int n = 0; n < 10; n++) begin
            jmp = (n >= 2) && (n % 3 == 2);
            nzp = (n < 2) ? 3'b010 : 3'($urandom);
            p   = (n == 0) ? 3'b010 : (n == 1) ? 3'b100 : 3'($urandom);
            ctrl = jmp ? {4'hC, 3'b000, 3'($urandom), 6'b0} : {4'h0, nzp, 9'($urandom)};
            exp_br = jmp || ((nzp & p) != 3'b000);
            IR = ctrl; IR_Exec = NEUT; psr = p; complete_instr = 1'b1;
            tick();
            chk("drn1_en", 16'(en), 16'b00110);
            chk("drn1_br", 16'(br_taken), 16'd0);
            IR = NEUT; IR_Exec = ctrl;
            tick();
            chk("drn2_en", 16'(en), 16'b00011);
            chk("drn2_br", 16'(br_taken), 16'(exp_br));
            IR_Exec = NEUT;
            tick();
            chk("drn3_en", 16'(en), 16'b10011);
            chk("drn3_br", 16'(br_taken), 16'd0);
            tick();
            chk("drn4_en", 16'(en), 16'b11011);
            tick();
            chk("drn5_en", 16'(en), 16'b11111);
        end

        // directed RAW hazard: ADD R0,R1,R2 in execute, ADD R1,R0,R0 in decode
        IR_Exec = 16'h1042; IR = 16'h1200;
        #1;
        chk("hz_byp1", 16'(bypass_alu_1), 16'(BYP));
        chk("hz_byp2", 16'(bypass_alu_2), 16'(BYP));
        tick();
        chk("hz_en1", 16'(en), BYP ? 16'b11111 : 16'b00010);
        tick();
        chk("hz_en2", 16'(en), 16'b11111);
        IR = NEUT; IR_Exec = NEUT;
        tick();
        chk("hz_en3", 16'(en), 16'b11111);

        // random ALU/other instruction pairs with random instruction-memory stalls
        stalled = 1'b0;
        for (int n = 0; n < 80; n++) begin
            ir = mk(plain_ops[$urandom_range(0, 7)]);
            ix = mk(plain_ops[$urandom_range(0, 7)]);
            ci = ($urandom_range(0, 3) != 0);
            IR = ir; IR_Exec = ix; complete_instr = ci;
            #1;
            a1 = is_alu(ir) && is_alu(ix) && (ir[8:6] == ix[11:9]);
            a2 = is_alu(ir) && is_alu(ix) && (ir[15:12] != 4'h9) && !ir[5] && (ir[2:0] == ix[11:9]);
            chk("rnd_byp1", 16'(bypass_alu_1), 16'(BYP & a1));
            chk("rnd_byp2", 16'(bypass_alu_2), 16'(BYP & a2));
            stall = !BYP && (a1 || a2) && !stalled;
            tick();
            chk("rnd_en", 16'(en), (ci && !stall) ? 16'b11111 : 16'b00010);
            stalled = stall;
        end
        IR = NEUT; IR_Exec = NEUT; complete_instr = 1'b1;
        tick();
        chk("rnd_done_en", 16'(en), 16'b11111);

        // data access never completes: forced back to IDLE after 15 cycles, sticky flag
        IR_Exec = 16'h2202; complete_data = 1'b1;
        tick();
        chk("to_enter_ms", 16'(mem_state), 16'd0);
        IR_Exec = NEUT; complete_data = 1'b0;
        for (int k = 1; k <= 14; k++) begin
            tick();
            chk("to_wait_ms", 16'(mem_state), 16'd0);
            chk("to_wait_flag", 16'(mem_timeout), 16'd0);
        end
        tick();
        chk("to_ms", 16'(mem_state), 16'd3);
        chk("to_flag", 16'(mem_timeout), 16'd1);
        chk("to_en", 16'(en), 16'b11111);
        complete_data = 1'b1;
        repeat (3) begin
            tick();
            chk("to_sticky", 16'(mem_timeout), 16'd1);
        end

        // asynchronous reset in the middle of a READ
        IR_Exec = 16'h6000;
        tick();
        chk("mr_ms", 16'(mem_state), 16'd0);
        IR_Exec = NEUT; complete_data = 1'b0;
        tick();
        #3;
        reset = 1'b1;
        #1;
        chk("mr_rst_ms", 16'(mem_state), 16'd3);
        chk("mr_rst_en", 16'(en), 16'd0);
        chk("mr_rst_br", 16'(br_taken), 16'd0);
        chk("mr_rst_to", 16'(mem_timeout), 16'd0);
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        fill_check("refill");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
